rifl_ber_mon: RTL and testbench

- Receive-side bit-error-rate monitor for RIFL link testing; the checking counterpart of the pseudo-random error-injection path.
- The transmitter sends a PRBS-31 pattern, and errors may be injected into it on the way. This block self-synchronises to the received PRBS, regenerates the expected pattern and counts mismatched bits and words.
- It sits on the RX user-data path after the lane/descrambler logic. Its counters feed the link statistics registers.

---
 rtl/rifl_ber_mon_if.sv | 11 +
 rtl/rifl_ber_mon.sv | 161 ++++++++++++++++
 tb/tb_rifl_ber_mon.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rifl_ber_mon_if.sv
// RX user-data beat bundle feeding the RIFL BER monitor.
// Carries no backpressure: the receiver must accept every beat offered.
interface rifl_ber_mon_if #(
   parameter int DWIDTH = 64
);
   logic              rx_valid;
   logic [DWIDTH-1:0] rx_data;

   modport master (output rx_valid, rx_data);
   modport slave  (input  rx_valid, rx_data);
endinterface

// File: rtl/rifl_ber_mon.sv
// PRBS-31 self-synchronising bit-error-rate monitor for the RIFL RX data path.
// Latency: 2 cycles from beat to counters/locked; no backpressure, idle cycles simply hold state.
module rifl_ber_mon #(
   parameter int DWIDTH   = 64,
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 8,
   parameter int CNT_W    = 48
) (
   input  logic               clk,
   input  logic               rst_n,
   rifl_ber_mon_if.slave      rx,
   input  logic               clr,
   output logic               locked,
   output logic [CNT_W-1:0]   bit_err_cnt,
   output logic [CNT_W-1:0]   word_err_cnt,
   output logic [CNT_W-1:0]   word_cnt,
   output logic [15:0]        lock_loss_cnt
);
   localparam int PCW = $clog2(DWIDTH + 1);
   localparam int SW  = CNT_W + PCW + 1;

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t            state, state_nxt;
   logic [7:0]        good_run, good_nxt, bad_run, bad_nxt;
   logic              seed, seed_nxt, lost, count_en;
   logic [30:0]       rx_hist, pred;
   logic [DWIDTH-1:0] exp_beat, s1_xor;
   logic              s1_vld;
   logic [PCW-1:0]    err_bits;

   // history bit 0 is the oldest serial bit, bit 30 the most recent
   function automatic logic [DWIDTH-1:0] prbs_next(input logic [30:0] hist);
      logic [30:0]       h;
      logic              b;
      logic [DWIDTH-1:0] beat;
      h    = hist;
      beat = '0;
      for (int i = 0; i < DWIDTH; i++) begin
         b       = h[0] ^ h[3];
         beat[i] = b;
         h       = {b, h[30:1]};
      end
      return beat;
   endfunction

   function automatic logic [PCW-1:0] popcount(input logic [DWIDTH-1:0] v);
      logic [PCW-1:0] c;
      c = '0;
      for (int i = 0; i < DWIDTH; i++) c = c + PCW'(v[i]);
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PCW-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // On the SEARCH->LOCKED edge the locking beat was error-free, so the
   // self-sync and free-running predictions coincide for the next beat.
   assign exp_beat = prbs_next((state == LOCKED) ? pred : rx_hist);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_xor  <= '0;
         rx_hist <= '0;
         pred    <= '0;
      end else begin
         s1_vld <= rx.rx_valid;
         if (rx.rx_valid) begin
            s1_xor  <= rx.rx_data ^ exp_beat;
            rx_hist <= rx.rx_data[DWIDTH-1 -: 31];
            pred    <= exp_beat[DWIDTH-1 -: 31];
         end
      end
   end

   assign err_bits = popcount(s1_xor);

   always_comb begin
      state_nxt = state;
      good_nxt  = good_run;
      bad_nxt   = bad_run;
      seed_nxt  = seed;
      lost      = 1'b0;
      count_en  = 1'b0;
      if (s1_vld) begin
         unique case (state)
            SEARCH: begin
               if (seed) begin
                  seed_nxt = 1'b0;
               end else if (err_bits == '0) begin
                  if (good_run == 8'(LOCK_CNT - 1)) begin
                     state_nxt = LOCKED;
                     good_nxt  = '0;
                  end else begin
                     good_nxt = good_run + 8'd1;
                  end
               end else begin
                  good_nxt = '0;
               end
            end
            LOCKED: begin
               count_en = 1'b1;
               if (err_bits > PCW'(DWIDTH / 4)) begin
                  if (bad_run == 8'(LOSS_CNT - 1)) begin
                     state_nxt = SEARCH;
                     bad_nxt   = '0;
                     good_nxt  = '0;
                     seed_nxt  = 1'b1;
                     lost      = 1'b1;
                  end else begin
                     bad_nxt = bad_run + 8'd1;
                  end
               end else begin
                  bad_nxt = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SEARCH;
         good_run <= '0;
         bad_run  <= '0;
         seed     <= 1'b1;
      end else begin
         state    <= state_nxt;
         good_run <= good_nxt;
         bad_run  <= bad_nxt;
         seed     <= seed_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_err_cnt   <= '0;
         word_err_cnt  <= '0;
         word_cnt      <= '0;
         lock_loss_cnt <= '0;
      end else if (clr) begin
         bit_err_cnt   <= '0;
         word_err_cnt  <= '0;
         word_cnt      <= '0;
         lock_loss_cnt <= '0;
      end else begin
         if (count_en) begin
            word_cnt     <= sat_add(word_cnt, PCW'(1));
            bit_err_cnt  <= sat_add(bit_err_cnt, err_bits);
            word_err_cnt <= sat_add(word_err_cnt, PCW'(err_bits != '0));
         end
         if (lost && lock_loss_cnt != 16'hFFFF) lock_loss_cnt <= lock_loss_cnt + 16'd1;
      end
   end

   assign locked = (state == LOCKED);
endmodule

// File: tb/tb_rifl_ber_mon.sv
// Randomised bench for rifl_ber_mon: a 48-bit and an 8-bit counter build share one stimulus stream.
// A beat-level reference model predicts locked and all counters every cycle.
module tb_rifl_ber_mon;
   localparam int DW   = 64;
   localparam int LOCK = 16;
   localparam int LOSS = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   rifl_ber_mon_if #(.DWIDTH(DW)) rx_if ();

   logic        locked_a, locked_b;
   logic [47:0] bit_a, werr_a, wcnt_a;
   logic [7:0]  bit_b, werr_b, wcnt_b;
   logic [15:0] loss_a, loss_b;

   rifl_ber_mon #(.DWIDTH(DW), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(48)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_if), .clr(clr), .locked(locked_a),
      .bit_err_cnt(bit_a), .word_err_cnt(werr_a), .word_cnt(wcnt_a), .lock_loss_cnt(loss_a));

   rifl_ber_mon #(.DWIDTH(DW), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_if), .clr(clr), .locked(locked_b),
      .bit_err_cnt(bit_b), .word_err_cnt(werr_b), .word_cnt(wcnt_b), .lock_loss_cnt(loss_b));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // serial sequence built out by index: s[n] = s[n-31] ^ s[n-28]
   function automatic logic [63:0] predict(input logic [30:0] h);
      bit          s [0:94];
      logic [63:0] r;
      for (int k = 0; k < 31; k++) s[k] = h[k];
      for (int n = 31; n < 95; n++) s[n] = s[n-31] ^ s[n-28];
      for (int i = 0; i < 64; i++) r[i] = s[31+i];
      return r;
   endfunction

   function automatic logic [63:0] sat8(input longint x);
      return (x > 255) ? 64'd255 : 64'(x);
   endfunction

   // transmitter
   logic [30:0] tx_h;
   function automatic logic [63:0] next_tx();
      logic [63:0] d;
      d    = predict(tx_h);
      tx_h = d[63:33];
      return d;
   endfunction

   // reference model
   bit          m_locked, m_seed, m_s1v;
   int          m_good, m_bad;
   longint      m_words, m_bits, m_werr, m_loss;
   logic [30:0] m_rxh, m_ref;
   logic [63:0] m_s1d;

   task automatic model_reset();
      m_locked = 0; m_seed = 1; m_s1v = 0; m_good = 0; m_bad = 0;
      m_words = 0; m_bits = 0; m_werr = 0; m_loss = 0;
      m_rxh = '0; m_ref = '0; m_s1d = '0;
   endtask

   task automatic model_step(input logic v, input logic [63:0] d, input logic c);
      logic [63:0] e;
      int          n;
      if (m_s1v) begin
         if (m_seed) begin
            m_seed = 0;
         end else if (!m_locked) begin
            e = predict(m_rxh);
            if (e == m_s1d) begin
               m_good++;
               if (m_good == LOCK) begin
                  m_locked = 1; m_good = 0; m_ref = e[63:33];
               end
            end else begin
               m_good = 0;
            end
         end else begin
            e = predict(m_ref);
            m_ref = e[63:33];
            n = $countones(e ^ m_s1d);
            m_words++;
            m_bits += n;
            if (n != 0) m_werr++;
            if (n > DW / 4) m_bad++; else m_bad = 0;
            if (m_bad == LOSS) begin
               m_locked = 0; m_bad = 0; m_good = 0; m_seed = 1; m_loss++;
            end
         end
         m_rxh = m_s1d[63:33];
      end
      if (c) begin
         m_words = 0; m_bits = 0; m_werr = 0; m_loss = 0;
      end
      m_s1v = v;
      m_s1d = d;
   endtask

   task automatic compare_all();
      chk("locked_a", 64'(locked_a), 64'(m_locked));
      chk("word_cnt_a", 64'(wcnt_a), 64'(m_words));
      chk("bit_err_a", 64'(bit_a), 64'(m_bits));
      chk("word_err_a", 64'(werr_a), 64'(m_werr));
      chk("lock_loss_a", 64'(loss_a), 64'(m_loss));
      chk("locked_b", 64'(locked_b), 64'(m_locked));
      chk("word_cnt_b", 64'(wcnt_b), sat8(m_words));
      chk("bit_err_b", 64'(bit_b), sat8(m_bits));
      chk("word_err_b", 64'(werr_b), sat8(m_werr));
      chk("lock_loss_b", 64'(loss_b), 64'(m_loss));
   endtask

   task automatic cyc(input logic v, input logic [63:0] d, input logic c);
      rx_if.rx_valid = v;
      rx_if.rx_data  = d;
      clr            = c;
      @(posedge clk);
      model_step(v, d, c);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, {$urandom, $urandom}, 1'b0);
   endtask

   task automatic send(input logic [63:0] d, input int gap);
      cyc(1'b1, d, 1'b0);
      idle(gap);
   endtask

   logic [63:0] d;

   initial begin
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = '0;
      model_reset();
      tx_h = 31'($urandom) | 31'd1;
      #12;
      chk("rst_locked", 64'(locked_a), 64'd0);
      chk("rst_word_cnt", 64'(wcnt_a), 64'd0);
      chk("rst_bit_err", 64'(bit_a), 64'd0);
      chk("rst_lock_loss", 64'(loss_a), 64'd0);
      rst_n = 1'b1;

      // clean lock from an arbitrary phase
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, next_tx(), 1'b0);
         if (i == 16) chk("lock_before_n2", 64'(locked_a), 64'd0);
         if (i == 17) chk("lock_at_n2", 64'(locked_a), 64'd1);
      end
      idle(2);
      chk("clean_word_cnt", 64'(wcnt_a), 64'd23);
      chk("clean_bit_err", 64'(bit_a), 64'd0);
      chk("clean_word_err", 64'(werr_a), 64'd0);

      // sparse errors do not propagate through the free-running predictor
      for (int i = 0; i < 100; i++) begin
         d = next_tx();
         if (i == 30) d[5] = ~d[5];
         if (i == 70) begin d[0] = ~d[0]; d[63] = ~d[63]; end
         send(d, $urandom_range(0, 2));
      end
      idle(2);
      chk("sparse_bit_err", 64'(bit_a), 64'd3);
      chk("sparse_word_err", 64'(werr_a), 64'd2);
      chk("sparse_word_cnt", 64'(wcnt_a), 64'd123);
      chk("sparse_locked", 64'(locked_a), 64'd1);

      // loss of lock on all-zero data, then relock
      for (int i = 0; i < 8; i++) begin
         d = next_tx();
         cyc(1'b1, 64'd0, 1'b0);
      end
      idle(2);
      chk("loss_locked", 64'(locked_a), 64'd0);
      chk("loss_count", 64'(loss_a), 64'd1);
      for (int i = 0; i < 17; i++) cyc(1'b1, next_tx(), 1'b0);
      idle(2);
      chk("relock", 64'(locked_a), 64'd1);

      // three idle cycles between beats, then random gaps with random errors
      for (int i = 0; i < 30; i++) begin
         d = next_tx();
         if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 63)] ^= 1'b1;
         send(d, 3);
      end
      for (int i = 0; i < 200; i++) begin
         d = next_tx();
         if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 63)] ^= 1'b1;
         send(d, $urandom_range(0, 1));
      end
      idle(2);
      chk("sat_word_cnt_b", 64'(wcnt_b), 64'd255);

      // clr coinciding with an errored beat's stage-2 update
      d = next_tx();
      d[10] = ~d[10];
      d[20] = ~d[20];
      cyc(1'b1, d, 1'b0);
      cyc(1'b1, next_tx(), 1'b1);
      chk("clr_word_cnt", 64'(wcnt_a), 64'd0);
      chk("clr_bit_err", 64'(bit_a), 64'd0);
      chk("clr_word_err", 64'(werr_a), 64'd0);
      chk("clr_lock_loss", 64'(loss_a), 64'd0);
      chk("clr_locked", 64'(locked_a), 64'd1);
      for (int i = 0; i < 10; i++) send(next_tx(), $urandom_range(0, 1));
      idle(2);

      // asynchronous reset between edges while locked
      for (int i = 0; i < 5; i++) cyc(1'b1, next_tx(), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_locked", 64'(locked_a), 64'd0);
      chk("arst_word_cnt", 64'(wcnt_a), 64'd0);
      chk("arst_bit_err", 64'(bit_a), 64'd0);
      chk("arst_word_err", 64'(werr_a), 64'd0);
      model_reset();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) cyc(1'b1, next_tx(), 1'b0);
      idle(2);
      chk("arst_seed_only", 64'(locked_a), 64'd0);
      cyc(1'b1, next_tx(), 1'b0);
      idle(2);
      chk("arst_relock", 64'(locked_a), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
